// File: rtl/alu_serial_n_bit.sv
// Digit-serial N-bit ALU: walks the operands LSB-first, DIGIT bits per clock,
// with a start/busy/done handshake and registered whole-word result flags.
module alu_serial_n_bit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [2:0]       Op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] O,
    output logic             Z,
    output logic             P,
    output logic             Cout,
    output logic             V
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("alu_serial_n_bit: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, o_q, o_d;
    logic [2:0]         op_q, op_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic               z_q, z_d, p_q, p_d, cout_q, cout_d, v_q, v_d;

    logic [DIGIT-1:0]   a_dig, b_dig, dig_res;
    logic [DIGIT:0]     sum_ext, diff_ext;
    logic               carry_nxt, last_dig, v_nxt;
    logic [WIDTH-1:0]   res_shift;

    // One digit of arithmetic per clock; the extra bit is the carry/borrow out.
    always_comb begin
        a_dig     = a_q[DIGIT-1:0];
        b_dig     = b_q[DIGIT-1:0];
        sum_ext   = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
        diff_ext  = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, carry_q};
        dig_res   = '0;
        carry_nxt = 1'b0;
        case (op_q)
            OP_ADD: begin
                dig_res   = sum_ext[DIGIT-1:0];
                carry_nxt = sum_ext[DIGIT];
            end
            OP_SUB: begin
                dig_res   = diff_ext[DIGIT-1:0];
                carry_nxt = diff_ext[DIGIT];
            end
            OP_OR:   dig_res = a_dig | b_dig;
            OP_AND:  dig_res = a_dig & b_dig;
            OP_NOT:  dig_res = ~a_dig;
            default: dig_res = '0;
        endcase
        res_shift = (res_q >> DIGIT) | (WIDTH'(dig_res) << (WIDTH - DIGIT));
        last_dig  = (cnt_q == CNT_W'(NDIG - 1));
        // Sign-based overflow test, equivalent to carry-in(MSB) ^ carry-out(MSB).
        v_nxt = 1'b0;
        if (op_q == OP_ADD)
            v_nxt = (a_msb_q == b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
        else if (op_q == OP_SUB)
            v_nxt = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        o_d     = o_q;
        z_d     = z_q;
        p_d     = p_q;
        cout_d  = cout_q;
        v_d     = v_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = Op;
                    carry_d = Cin;
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1];
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_shift;
                carry_d = carry_nxt;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_dig) begin
                    o_d     = res_shift;
                    z_d     = ~|res_shift;
                    p_d     = ^res_shift;
                    cout_d  = carry_nxt;
                    v_d     = v_nxt;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            o_q     <= '0;
            z_q     <= 1'b1;
            p_q     <= 1'b0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            o_q     <= o_d;
            z_q     <= z_d;
            p_q     <= p_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign O    = o_q;
    assign Z    = z_q;
    assign P    = p_q;
    assign Cout = cout_q;
    assign V    = v_q;

endmodule

// File: tb/tb_alu_serial_n_bit.sv
// Directed bench for alu_serial_n_bit: an 8-bit/1-bit-digit instance and a
// 16-bit/4-bit-digit instance driven from shared operand buses.
module tb_alu_serial_n_bit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start8, start16, cin_d;
    logic [15:0] a_d, b_d;
    logic [2:0]  op_d;

    logic        busy8, done8, z8, p8, c8, v8;
    logic [7:0]  o8;
    logic        busy16, done16, z16, p16, c16, v16;
    logic [15:0] o16;

    alu_serial_n_bit #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a_d[7:0]), .B(b_d[7:0]),
        .Cin(cin_d), .Op(op_d), .busy(busy8), .done(done8), .O(o8), .Z(z8),
        .P(p8), .Cout(c8), .V(v8)
    );

    alu_serial_n_bit #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .A(a_d), .B(b_d),
        .Cin(cin_d), .Op(op_d), .busy(busy16), .done(done16), .O(o16), .Z(z16),
        .P(p16), .Cout(c16), .V(v16)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation, then wait (bounded) for done; reports latency and busy cycles.
    task automatic do_op(input bit w16, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [2:0] op,
                         output logic [15:0] o, output logic z, output logic p,
                         output logic c, output logic v, output int lat, output int bcnt);
        @(negedge clk);
        a_d = a; b_d = b; cin_d = cin; op_d = op;
        if (w16) start16 = 1'b1; else start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; start16 = 1'b0;
        lat = 0; bcnt = 0;
        while (!(w16 ? done16 : done8) && lat < 40) begin
            if (w16 ? busy16 : busy8) bcnt++;
            @(negedge clk);
            lat++;
        end
        o = w16 ? o16 : {8'h00, o8};
        z = w16 ? z16 : z8;
        p = w16 ? p16 : p8;
        c = w16 ? c16 : c8;
        v = w16 ? v16 : v8;
    endtask

    typedef struct {
        logic [7:0] a, b;
        logic       cin;
        logic [2:0] op;
        logic [7:0] o;
        logic       z, p, c, v;
    } vec_t;

    initial begin
        vec_t        tv[13];
        logic [15:0] ro;
        logic        rz, rp, rc, rv;
        int          lat, bcnt;
        logic [7:0]  ha[0:31], hb[0:31];
        logic [8:0]  wide;
        bit          saw_done;

        //          a      b      cin   op      o      z     p     c     v
        tv[0]  = '{8'h7F, 8'h01, 1'b0, 3'b001, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
        tv[1]  = '{8'h00, 8'h01, 1'b0, 3'b010, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[2]  = '{8'h80, 8'h01, 1'b0, 3'b010, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1};
        tv[3]  = '{8'hF0, 8'h0F, 1'b0, 3'b101, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{8'h55, 8'h00, 1'b0, 3'b110, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{8'h5A, 8'hC3, 1'b1, 3'b011, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{8'hFF, 8'hFF, 1'b1, 3'b001, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[7]  = '{8'hA0, 8'h05, 1'b0, 3'b100, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{8'h80, 8'h80, 1'b0, 3'b001, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
        tv[9]  = '{8'h05, 8'h03, 1'b1, 3'b010, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[10] = '{8'hFF, 8'hFF, 1'b1, 3'b000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[11] = '{8'hFF, 8'h01, 1'b1, 3'b111, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[12] = '{8'h7F, 8'hFF, 1'b0, 3'b010, 8'h80, 1'b0, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0; start8 = 1'b0; start16 = 1'b0;
        a_d = '0; b_d = '0; cin_d = 1'b0; op_d = 3'b000;
        repeat (3) @(negedge clk);
        chk("rst busy", busy8, 0);
        chk("rst done", done8, 0);
        chk("rst O",    o8,    0);
        chk("rst Z",    z8,    1);
        chk("rst P",    p8,    0);
        chk("rst Cout", c8,    0);
        chk("rst V",    v8,    0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            do_op(1'b0, {8'h00, tv[i].a}, {8'h00, tv[i].b}, tv[i].cin, tv[i].op,
                  ro, rz, rp, rc, rv, lat, bcnt);
            chk($sformatf("v%0d latency", i), lat, 8);
            chk($sformatf("v%0d busy cycles", i), bcnt, 8);
            chk($sformatf("v%0d O", i), ro[7:0], tv[i].o);
            chk($sformatf("v%0d Z", i), rz, tv[i].z);
            chk($sformatf("v%0d P", i), rp, tv[i].p);
            chk($sformatf("v%0d Cout", i), rc, tv[i].c);
            chk($sformatf("v%0d V", i), rv, tv[i].v);
        end

        // Abort an add in its 4th RUN cycle with an async reset.
        @(negedge clk);
        a_d = 16'h00FF; b_d = 16'h00FF; cin_d = 1'b0; op_d = 3'b001; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort busy before", busy8, 1);
        chk("abort O held", o8, 8'h80);
        #1 rst_n = 1'b0;
        #1;
        chk("abort busy", busy8, 0);
        chk("abort done", done8, 0);
        chk("abort O",    o8,    0);
        chk("abort Z",    z8,    1);
        chk("abort Cout", c8,    0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8) saw_done = 1'b1;
        end
        chk("abort no done", saw_done, 0);
        do_op(1'b0, 16'h0012, 16'h0034, 1'b0, 3'b001, ro, rz, rp, rc, rv, lat, bcnt);
        chk("post-abort latency", lat, 8);
        chk("post-abort O", ro[7:0], 8'h46);
        chk("post-abort P", rp, 1);

        // start held high: accepts at negedge slots 0, 9, 18; done at 9, 18, 27.
        for (int n = 0; n <= 27; n++) begin
            @(negedge clk);
            if (n > 0) begin
                chk($sformatf("b2b done@%0d", n), done8, (n % 9 == 0));
                chk($sformatf("b2b busy@%0d", n), busy8, (n % 9 != 0));
                if (n % 9 == 0) begin
                    wide = {1'b0, ha[n-9]} + {1'b0, hb[n-9]};
                    chk($sformatf("b2b O@%0d", n), o8, wide[7:0]);
                    chk($sformatf("b2b Cout@%0d", n), c8, wide[8]);
                end
            end
            ha[n] = 8'(n * 29 + 100);
            hb[n] = 8'(n * 13 + 77);
            a_d = {8'h00, ha[n]}; b_d = {8'h00, hb[n]};
            cin_d = 1'b0; op_d = 3'b001;
            start8 = (n < 27);
        end
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        chk("b2b idle after", busy8 | done8, 0);

        do_op(1'b1, 16'hFFFF, 16'h0000, 1'b1, 3'b001, ro, rz, rp, rc, rv, lat, bcnt);
        chk("w16 add latency", lat, 4);
        chk("w16 add O",    ro, 16'h0000);
        chk("w16 add Cout", rc, 1);
        chk("w16 add Z",    rz, 1);
        chk("w16 add P",    rp, 0);
        chk("w16 add V",    rv, 0);
        do_op(1'b1, 16'h1234, 16'h0235, 1'b0, 3'b010, ro, rz, rp, rc, rv, lat, bcnt);
        chk("w16 sub latency", lat, 4);
        chk("w16 sub O",    ro, 16'h0FFF);
        chk("w16 sub Cout", rc, 0);
        chk("w16 sub P",    rp, 0);
        chk("w16 sub V",    rv, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
